// File: rtl/mag_integrate_dump_pkg.sv
// Shared types and helpers for the magnitude integrate-and-dump stage.
package mag_integrate_dump_pkg;

   typedef enum logic {ST_IDLE, ST_ACC} integ_state_t;

   // The sum width holds a full-scale window without overflow.
   function automatic int acc_width(input int in_w, input int len_w);
      return in_w + len_w;
   endfunction

endpackage

// File: rtl/mag_integrate_dump_if.sv
// Sample/window-control bus between the abs stage and the integrate-and-dump stage.
// Handshake: a sample transfers on every rising clk where we=1 and clear=0; there is no
// back-pressure. valid is a one-cycle pulse that marks a new sum (and peak).
interface mag_integrate_dump_if #(
   parameter int IN_WIDTH  = 8,
   parameter int LEN_WIDTH = 8
);
   localparam int ACC_WIDTH = IN_WIDTH + LEN_WIDTH;

   logic [IN_WIDTH-1:0]  in;
   logic                 we;
   logic [LEN_WIDTH-1:0] len;
   logic                 clear;
   logic [ACC_WIDTH-1:0] sum;
   logic                 valid;
   logic [IN_WIDTH-1:0]  peak;

   modport master (output in, we, len, clear, input sum, valid, peak);
   modport slave  (input in, we, len, clear, output sum, valid, peak);

endinterface

// File: rtl/mag_integrate_dump_peak_hold.sv
// Running maximum over one window; the max is published to peak when the window dumps.
module mag_peak_hold #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic [WIDTH-1:0] in,
   input  logic             we,
   input  logic             restart,
   input  logic             dump,
   output logic [WIDTH-1:0] peak
);

   logic [WIDTH-1:0] run_max;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] next_max;

   always_comb begin
      base     = restart ? '0 : run_max;
      next_max = (we && (in > base)) ? in : base;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         run_max <= '0;
         peak    <= '0;
      end else if (dump) begin
         peak    <= next_max;
         run_max <= '0;
      end else begin
         run_max <= next_max;
      end
   end

endmodule

// File: rtl/mag_integrate_dump.sv
// Integrate-and-dump: sums len+1 magnitude samples per window and pulses valid with the sum.
// Build option MAG_INTEGRATE_DUMP_PEAK_EN adds a per-window peak hold; otherwise peak is 0.
module mag_integrate_dump
   import mag_integrate_dump_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int LEN_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  aresetn,
   mag_integrate_dump_if.slave   bus,
   output integ_state_t          dbg_state
);

   localparam int ACC_WIDTH = acc_width(IN_WIDTH, LEN_WIDTH);

   integ_state_t          state, state_d;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  cnt;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH-1:0]  acc_sum;
   logic [ACC_WIDTH-1:0]  sum_q;
   logic                  valid_q;
   logic                  take;
   logic                  start;
   logic                  dump;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state <= ST_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (bus.clear) begin
         state_d = ST_IDLE;
      end else if (bus.we) begin
         case (state)
            ST_IDLE: state_d = (bus.len == '0) ? ST_IDLE : ST_ACC;
            ST_ACC:  if (cnt == len_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // In ST_IDLE the incoming sample seeds the window, so the old accumulator is ignored.
   always_comb begin
      take    = bus.we && !bus.clear;
      start   = take && (state == ST_IDLE);
      dump    = take && ((state == ST_IDLE) ? (bus.len == '0) : (cnt == len_q));
      acc_sum = ((state == ST_IDLE) ? '0 : acc) + ACC_WIDTH'(bus.in);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         len_q   <= '0;
         cnt     <= '0;
         acc     <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (bus.clear) begin
            acc <= '0;
            cnt <= '0;
         end else if (take) begin
            if (start) len_q <= bus.len;
            if (dump) begin
               sum_q   <= acc_sum;
               valid_q <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
            end else begin
               acc <= acc_sum;
               cnt <= cnt + LEN_WIDTH'(1);
            end
         end
      end
   end

   assign bus.sum   = sum_q;
   assign bus.valid = valid_q;
   assign dbg_state = state;

`ifdef MAG_INTEGRATE_DUMP_PEAK_EN
   logic [IN_WIDTH-1:0] peak_q;
   logic                peak_restart;

   assign peak_restart = bus.clear || (state == ST_IDLE);

   mag_peak_hold #(.WIDTH(IN_WIDTH)) u_peak (
      .clk     (clk),
      .aresetn (aresetn),
      .in      (bus.in),
      .we      (take),
      .restart (peak_restart),
      .dump    (dump),
      .peak    (peak_q)
   );

   assign bus.peak = peak_q;
`else
   assign bus.peak = '0;
`endif

endmodule

// File: tb/tb_mag_integrate_dump.sv
// Directed bench for mag_integrate_dump with hand-computed window sums and peaks.
module tb_mag_integrate_dump;
   import mag_integrate_dump_pkg::*;

   logic         clk;
   logic         aresetn;
   integ_state_t dbg_state;
   int           total;
   int           bad;
   int           early;

   mag_integrate_dump_if #(.IN_WIDTH(8), .LEN_WIDTH(8)) bus ();

   mag_integrate_dump #(.IN_WIDTH(8), .LEN_WIDTH(8)) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pk(input logic [7:0] v);
`ifdef MAG_INTEGRATE_DUMP_PEAK_EN
      return v;
`else
      return (v == v) ? 8'd0 : 8'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] v);
      bus.in = v;
      bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      early = 0;
      aresetn   = 1'b0;
      bus.in    = '0;
      bus.we    = 1'b0;
      bus.len   = 8'd3;
      bus.clear = 1'b0;
      tick();
      check("rst_sum", 32'(bus.sum), 0);
      check("rst_valid", 32'(bus.valid), 0);
      check("rst_peak", 32'(bus.peak), 0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      aresetn = 1'b1;
      tick();

      // 1: four consecutive samples
      send(8'd1); check("t1_v1", 32'(bus.valid), 0);
      check("t1_state", 32'(dbg_state), 32'(ST_ACC));
      send(8'd2); check("t1_v2", 32'(bus.valid), 0);
      send(8'd3); check("t1_v3", 32'(bus.valid), 0);
      send(8'd4);
      check("t1_valid", 32'(bus.valid), 1);
      check("t1_sum", 32'(bus.sum), 10);
      check("t1_peak", 32'(bus.peak), 32'(pk(8'd4)));
      tick();
      check("t1_pulse_end", 32'(bus.valid), 0);
      check("t1_sum_hold", 32'(bus.sum), 10);

      // 2: samples with two-cycle gaps
      send(8'd5); tick(); check("t2_gap_a", 32'(bus.valid), 0); tick();
      send(8'd6); tick(); check("t2_gap_b", 32'(bus.valid), 0); tick();
      send(8'd7); tick(); check("t2_gap_c", 32'(bus.valid), 0); tick();
      check("t2_gap_c2", 32'(bus.valid), 0);
      send(8'd8);
      check("t2_valid", 32'(bus.valid), 1);
      check("t2_sum", 32'(bus.sum), 26);
      check("t2_peak", 32'(bus.peak), 32'(pk(8'd8)));

      // len=0: one-sample windows back to back
      bus.len = 8'd0;
      send(8'd7);
      check("l0_valid_a", 32'(bus.valid), 1);
      check("l0_sum_a", 32'(bus.sum), 7);
      send(8'd8);
      check("l0_valid_b", 32'(bus.valid), 1);
      check("l0_sum_b", 32'(bus.sum), 8);
      check("l0_peak_b", 32'(bus.peak), 32'(pk(8'd8)));

      // len changes mid-window only affect the next window
      bus.len = 8'd1;
      send(8'd2);
      bus.len = 8'd3;
      send(8'd3);
      check("lchg_valid", 32'(bus.valid), 1);
      check("lchg_sum", 32'(bus.sum), 5);

      // 3: full-scale window then window of ones, no gap
      bus.len = 8'd255;
      for (int i = 0; i < 256; i++) begin
         send(8'd255);
         if (i < 255 && bus.valid) early++;
      end
      check("t3_valid_a", 32'(bus.valid), 1);
      check("t3_sum_a", 32'(bus.sum), 65280);
      check("t3_peak_a", 32'(bus.peak), 32'(pk(8'd255)));
      for (int i = 0; i < 256; i++) begin
         send(8'd1);
         if (i == 0) check("t3_hold", 32'(bus.sum), 65280);
         if (i < 255 && bus.valid) early++;
      end
      check("t3_valid_b", 32'(bus.valid), 1);
      check("t3_sum_b", 32'(bus.sum), 256);
      check("t3_peak_b", 32'(bus.peak), 32'(pk(8'd1)));
      check("t3_early", 32'(early), 0);

      // 4: clear with a simultaneous sample discards the window
      bus.len = 8'd3;
      send(8'd9); send(8'd9);
      bus.clear = 1'b1;
      send(8'd9);
      bus.clear = 1'b0;
      check("t4_clr_valid", 32'(bus.valid), 0);
      check("t4_clr_sum", 32'(bus.sum), 256);
      check("t4_clr_state", 32'(dbg_state), 32'(ST_IDLE));
      send(8'd1); check("t4_v1", 32'(bus.valid), 0);
      send(8'd1); check("t4_v2", 32'(bus.valid), 0);
      send(8'd1); check("t4_v3", 32'(bus.valid), 0);
      check("t4_hold", 32'(bus.sum), 256);
      send(8'd1);
      check("t4_valid", 32'(bus.valid), 1);
      check("t4_sum", 32'(bus.sum), 4);
      check("t4_peak", 32'(bus.peak), 32'(pk(8'd1)));

      // 5: asynchronous reset mid-window
      send(8'd6); send(8'd6);
      #2 aresetn = 1'b0;
      #1;
      check("t5_rst_sum", 32'(bus.sum), 0);
      check("t5_rst_valid", 32'(bus.valid), 0);
      check("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      #2 aresetn = 1'b1;
      tick();
      send(8'd3); send(8'd3); send(8'd3);
      check("t5_v3", 32'(bus.valid), 0);
      send(8'd3);
      check("t5_valid", 32'(bus.valid), 1);
      check("t5_sum", 32'(bus.sum), 12);

      // 6: peak tracking
      send(8'd5); send(8'd9); send(8'd2); send(8'd7);
      check("t6_valid_a", 32'(bus.valid), 1);
      check("t6_sum_a", 32'(bus.sum), 23);
      check("t6_peak_a", 32'(bus.peak), 32'(pk(8'd9)));
      send(8'd1); send(8'd1); send(8'd1);
      check("t6_peak_hold", 32'(bus.peak), 32'(pk(8'd9)));
      send(8'd1);
      check("t6_sum_b", 32'(bus.sum), 4);
      check("t6_peak_b", 32'(bus.peak), 32'(pk(8'd1)));
      tick();
      check("t6_end_valid", 32'(bus.valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
